tlb_ram_array: RTL and testbench



---
 rtl/tlb_ram_array.sv | 95 +++++++++
 tb/tb_tlb_ram_array.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tlb_ram_array.sv
// TLB storage back-end: dual registered read ports with write/clear forwarding,
// single write port, per-entry valid bits, purge-all sequencer and victim pointer.
module tlb_ram_array #(
  parameter int ADR_W  = 3,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADR_W-1:0]  readAdrA,
  input  logic [ADR_W-1:0]  readAdrB,
  output logic [DATA_W-1:0] dataOutA,
  output logic [DATA_W-1:0] dataOutB,
  output logic              validOutA,
  output logic              validOutB,
  input  logic              wEnable,
  input  logic [ADR_W-1:0]  writeAdr,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              invEnable,
  input  logic [ADR_W-1:0]  invAdr,
  input  logic              purgeReq,
  output logic              busy,
  output logic [ADR_W-1:0]  victimAdr
);
  localparam int ENTRIES = 2**ADR_W;

  typedef enum logic {IDLE, PURGE} state_t;

  logic [DATA_W-1:0]  mem [ENTRIES];
  logic [ENTRIES-1:0] valid, valid_nxt;
  state_t             state;
  logic [ADR_W-1:0]   pc, rr_ptr, rr_nxt, victim_nxt;
  logic               wr_acc, inv_acc;

  assign wr_acc  = wEnable   && (state == IDLE);
  assign inv_acc = invEnable && (state == IDLE);

  // Clears apply first so an accepted write to the same entry wins.
  always_comb begin
    valid_nxt = valid;
    if (inv_acc)          valid_nxt[invAdr]   = 1'b0;
    if (state == PURGE)   valid_nxt[pc]       = 1'b0;
    if (wr_acc)           valid_nxt[writeAdr] = 1'b1;
  end

  // Round-robin only advances when a write replaces a live entry.
  assign rr_nxt = (wr_acc && (&valid)) ? rr_ptr + 1'b1 : rr_ptr;

  always_comb begin
    victim_nxt = rr_nxt;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (!valid_nxt[i]) victim_nxt = ADR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[writeAdr] <= dataIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= '0;
      state     <= IDLE;
      pc        <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      victimAdr <= '0;
      dataOutA  <= '0;
      dataOutB  <= '0;
      validOutA <= 1'b0;
      validOutB <= 1'b0;
    end else begin
      valid     <= valid_nxt;
      rr_ptr    <= rr_nxt;
      victimAdr <= victim_nxt;
      dataOutA  <= (wr_acc && writeAdr == readAdrA) ? dataIn : mem[readAdrA];
      dataOutB  <= (wr_acc && writeAdr == readAdrB) ? dataIn : mem[readAdrB];
      validOutA <= valid_nxt[readAdrA];
      validOutB <= valid_nxt[readAdrB];
      case (state)
        IDLE: if (purgeReq) begin
          state <= PURGE;
          pc    <= '0;
          busy  <= 1'b1;
        end
        PURGE: begin
          pc <= pc + 1'b1;
          if (&pc) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb_ram_array.sv
// Randomized + directed bench for tlb_ram_array against an array-based reference model.
module tb_tlb_ram_array;
  localparam int AW = 3;
  localparam int DW = 48;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] readAdrA = '0, readAdrB = '0, writeAdr = '0, invAdr = '0;
  logic [DW-1:0] dataOutA, dataOutB, dataIn = '0;
  logic          validOutA, validOutB, wEnable = 1'b0, invEnable = 1'b0, purgeReq = 1'b0;
  logic          busy;
  logic [AW-1:0] victimAdr;

  tlb_ram_array #(.ADR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .readAdrA(readAdrA), .readAdrB(readAdrB),
    .dataOutA(dataOutA), .dataOutB(dataOutB), .validOutA(validOutA), .validOutB(validOutB),
    .wEnable(wEnable), .writeAdr(writeAdr), .dataIn(dataIn),
    .invEnable(invEnable), .invAdr(invAdr), .purgeReq(purgeReq),
    .busy(busy), .victimAdr(victimAdr));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arrays, evaluated once per clock from the rules.
  bit [DW-1:0] m_mem [N];
  bit          m_val [N];
  bit          m_known [N];
  bit          m_busy;
  int          m_pc, m_rr, m_vic;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_val[i] = 0;
    m_busy = 0; m_pc = 0; m_rr = 0; m_vic = 0;
  endtask

  task automatic cyc(input bit we, input int wa, input bit [DW-1:0] din,
                     input bit ie, input int ia, input bit preq,
                     input int ra, input int rb);
    bit acc_w, acc_i, allv;
    bit nval [N];
    bit [DW-1:0] e_da, e_db;
    bit e_va, e_vb, e_ka, e_kb;
    wEnable = we; writeAdr = AW'(wa); dataIn = din;
    invEnable = ie; invAdr = AW'(ia); purgeReq = preq;
    readAdrA = AW'(ra); readAdrB = AW'(rb);
    acc_w = we && !m_busy;
    acc_i = ie && !m_busy;
    allv = 1;
    for (int i = 0; i < N; i++) begin
      nval[i] = m_val[i];
      if (!m_val[i]) allv = 0;
    end
    if (acc_i)  nval[ia]   = 0;
    if (m_busy) nval[m_pc] = 0;
    if (acc_w)  nval[wa]   = 1;
    if (acc_w && wa == ra) begin e_da = din; e_ka = 1; end
    else begin e_da = m_mem[ra]; e_ka = m_known[ra]; end
    if (acc_w && wa == rb) begin e_db = din; e_kb = 1; end
    else begin e_db = m_mem[rb]; e_kb = m_known[rb]; end
    e_va = nval[ra];
    e_vb = nval[rb];
    if (acc_w) begin m_mem[wa] = din; m_known[wa] = 1; end
    if (acc_w && allv) m_rr = (m_rr + 1) % N;
    if (m_busy) begin
      if (m_pc == N-1) m_busy = 0;
      else m_pc++;
    end else if (preq) begin
      m_busy = 1; m_pc = 0;
    end
    m_vic = -1;
    for (int i = 0; i < N; i++) begin
      m_val[i] = nval[i];
      if (!nval[i] && m_vic < 0) m_vic = i;
    end
    if (m_vic < 0) m_vic = m_rr;
    @(posedge clk); #1;
    chk("validA", 64'(validOutA), 64'(e_va));
    chk("validB", 64'(validOutB), 64'(e_vb));
    if (e_ka) chk("dataA", 64'(dataOutA), 64'(e_da));
    if (e_kb) chk("dataB", 64'(dataOutB), 64'(e_db));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("victim", 64'(victimAdr), 64'(m_vic));
  endtask

  task automatic idle_read(input int ra, input int rb);
    cyc(0, 0, '0, 0, 0, 0, ra, rb);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_vA"},     64'(validOutA), 64'd0);
    chk({tag, "_vB"},     64'(validOutB), 64'd0);
    chk({tag, "_dA"},     64'(dataOutA), 64'd0);
    chk({tag, "_dB"},     64'(dataOutB), 64'd0);
    chk({tag, "_victim"}, 64'(victimAdr), 64'd0);
  endtask

  initial begin
    int blen;
    bit [DW-1:0] rd;
    for (int i = 0; i < N; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    model_reset();
    #12;
    reset_checks("rst");
    rst = 1'b1;
    idle_read(0, 7);

    // write and dual read
    cyc(1, 0, 48'h001200120034, 0, 0, 0, 1, 3);
    chk("victim_w0", 64'(victimAdr), 64'd1);
    cyc(1, 2, 48'h120012003400, 0, 0, 0, 1, 3);
    chk("victim_w2", 64'(victimAdr), 64'd1);
    idle_read(0, 2);
    chk("rd0", 64'(dataOutA), 64'h001200120034);
    chk("rd2", 64'(dataOutB), 64'h120012003400);

    // same-edge forwarding, then write vs invalidate conflict
    cyc(1, 5, 48'hABCDEF012345, 0, 0, 0, 5, 5);
    chk("fwdA", 64'(dataOutA), 64'hABCDEF012345);
    chk("fwdB", 64'(dataOutB), 64'hABCDEF012345);
    chk("fwdV", 64'({validOutA, validOutB}), 64'd3);
    cyc(1, 5, 48'h5555AAAA5555, 1, 5, 0, 5, 0);
    idle_read(5, 5);
    chk("wr_wins", 64'(validOutA), 64'd1);

    // fill and round-robin wrap
    for (int i = 0; i < N; i++) cyc(1, i, DW'(i * 48'h10101), 0, 0, 0, i, 7 - i);
    chk("fill_victim", 64'(victimAdr), 64'd0);
    for (int k = 0; k < 9; k++) begin
      cyc(1, m_vic, {$urandom, $urandom}, 0, 0, 0, k % N, 0);
      chk("rr_step", 64'(victimAdr), 64'((k + 1) % N));
    end

    // purge: busy width, ignored write
    cyc(0, 0, '0, 0, 0, 1, 0, 0);
    blen = 0;
    while (busy && blen < 20) begin
      blen++;
      if (blen == 4) cyc(1, 3, 48'hDEAD, 0, 0, 1, 3, 3);
      else           idle_read(blen % N, 0);
    end
    chk("busy_len", 64'(blen), 64'd8);
    for (int i = 0; i < N; i++) idle_read(i, N - 1 - i);
    chk("purge_victim", 64'(victimAdr), 64'd0);

    // reset in purge cycle 3
    for (int i = 0; i < N; i++) cyc(1, i, {$urandom, $urandom}, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 1, 0, 0);
    idle_read(1, 2);
    idle_read(1, 2);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    reset_checks("rst2");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 4, 48'h444444444444, 0, 0, 0, 4, 4);
    cyc(0, 0, '0, 1, 4, 0, 4, 4);
    idle_read(4, 4);
    chk("inv_valid", 64'(validOutA), 64'd0);
    chk("inv_victim", 64'(victimAdr), 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rd = {$urandom, $urandom};
      cyc($urandom_range(0, 99) < 45,
          ($urandom_range(0, 1) != 0) ? m_vic : int'($urandom_range(0, N-1)), rd,
          $urandom_range(0, 99) < 20, $urandom_range(0, N-1),
          $urandom_range(0, 99) < 3,
          $urandom_range(0, N-1), $urandom_range(0, N-1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
